// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port sequencer: FSM states, width codes, request types.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // ls_width encodings; 3 behaves like a word
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    // ls_type encodings
    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    // Address field compared against IO_MASK to detect IO space
    localparam int IO_FIELD_HI = 17;
    localparam int IO_FIELD_LO = 16;

    // Identity of the requester that won the previous arbitration
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    // Number of RAM byte cycles for an LSB width code
    function automatic logic [2:0] width_to_bytes(input logic [1:0] w);
        case (w)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            WIDTH_WORD: return 3'd4;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker (IF vs LSB); a tie goes to whoever did not win last.
// Latency: combinational grant, last_grant register updates on the grant edge.
// Backpressure: grants only while en_i is high; last_grant holds otherwise.
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_if_i,
    input  logic req_ls_i,
    output logic gnt_if_o,
    output logic gnt_ls_o
);

    logic last_q;
    logic last_d;

    // Pick a winner and compute the updated last-grant owner
    always_comb begin
        gnt_ls_o = en_i && req_ls_i && (!req_if_i || (last_q == GRANT_IF));
        gnt_if_o = en_i && req_if_i && (!req_ls_i || (last_q == GRANT_LS));
        last_d   = last_q;
        if (gnt_ls_o) begin
            last_d = GRANT_LS;
        end else if (gnt_if_o) begin
            last_d = GRANT_IF;
        end
    end

    // Remember the last winner; reset favours LSB on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GRANT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the byte-wide RAM port between fetch and LSB, splitting each access into byte cycles.
// Latency: store N+1 cycles grant-to-done (+IO wait), load/fetch done pulse N+2 cycles after grant.
// Backpressure: one transaction at a time; requesters hold until done, rdy low freezes, IO full stalls stores.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int         ROBBW   = 4,
    parameter logic [1:0] IO_MASK = 2'b11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             io_buffer_full,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    input  logic             flush,
    output logic             if_done,
    output logic [31:0]      if_data,
    input  logic             ls_req,
    input  logic             ls_type,
    input  logic [1:0]       ls_width,
    input  logic [31:0]      ls_addr,
    input  logic [31:0]      ls_val,
    input  logic [ROBBW-1:0] ls_rob_id,
    output logic             ls_done,
    output logic             ld_cdb_flag,
    output logic [31:0]      ld_cdb_val,
    output logic [ROBBW-1:0] ld_cdb_rob_id
);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       n_q, n_d;
    logic [31:0]      base_q, base_d;
    logic             store_q, store_d;
    logic             fetch_q, fetch_d;
    logic [31:0]      val_q, val_d;
    logic [ROBBW-1:0] rob_q, rob_d;
    logic [31:0]      data_q, data_d;
    logic             if_done_q, if_done_d;
    logic             ls_done_q, ls_done_d;
    logic             ld_flag_q, ld_flag_d;

    logic       gnt_if, gnt_ls;
    logic       arb_en;
    logic       io_hit;
    logic [1:0] cap_idx;

    assign arb_en  = rdy && (state_q == ST_IDLE);
    assign io_hit  = (ls_addr[IO_FIELD_HI:IO_FIELD_LO] == IO_MASK);
    // Byte lane receiving mem_din: the read issued one cycle earlier (cnt-1)
    assign cap_idx = cnt_q[1:0] - 2'd1;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (arb_en),
        .req_if_i (if_req && !flush),
        .req_ls_i (ls_req),
        .gnt_if_o (gnt_if),
        .gnt_ls_o (gnt_ls)
    );

    // Next-state logic: grant/latch in IDLE, byte sequencing in RUN, one-cycle DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        base_d    = base_q;
        store_d   = store_q;
        fetch_d   = fetch_q;
        val_d     = val_q;
        rob_d     = rob_q;
        data_d    = data_q;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        ld_flag_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_ls) begin
                    base_d  = ls_addr;
                    n_d     = width_to_bytes(ls_width);
                    store_d = (ls_type == LS_STORE);
                    fetch_d = 1'b0;
                    val_d   = ls_val;
                    rob_d   = ls_rob_id;
                    data_d  = '0;
                    cnt_d   = '0;
                    if ((ls_type == LS_STORE) && io_hit && io_buffer_full) begin
                        state_d = ST_IO_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (gnt_if) begin
                    base_d  = if_addr;
                    n_d     = 3'd4;
                    store_d = 1'b0;
                    fetch_d = 1'b1;
                    data_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetch_q && flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (store_q) begin
                        if (cnt_q == n_q - 3'd1) begin
                            state_d   = ST_DONE;
                            ls_done_d = 1'b1;
                        end
                    end else begin
                        if (cnt_q != 3'd0) begin
                            data_d[{cap_idx, 3'b000} +: 8] = mem_din;
                        end
                        // Reads run one cycle past N so the last byte can land
                        if (cnt_q == n_q) begin
                            state_d = ST_DONE;
                            if (fetch_q) begin
                                if_done_d = 1'b1;
                            end else begin
                                ls_done_d = 1'b1;
                                ld_flag_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM pins decode from registered state only; rdy low suppresses writes
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (state_q == ST_RUN) begin
            mem_a = base_q + {29'd0, cnt_q};
            if (store_q) begin
                mem_dout = val_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy && (cnt_q < n_q);
            end
        end
    end

    // State and latch registers; everything holds while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            base_q    <= '0;
            store_q   <= 1'b0;
            fetch_q   <= 1'b0;
            val_q     <= '0;
            rob_q     <= '0;
            data_q    <= '0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            ld_flag_q <= 1'b0;
        end else if (rdy) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            base_q    <= base_d;
            store_q   <= store_d;
            fetch_q   <= fetch_d;
            val_q     <= val_d;
            rob_q     <= rob_d;
            data_q    <= data_d;
            if_done_q <= if_done_d;
            ls_done_q <= ls_done_d;
            ld_flag_q <= ld_flag_d;
        end
    end

    assign if_done       = if_done_q;
    assign if_data       = data_q;
    assign ls_done       = ls_done_q;
    assign ld_cdb_flag   = ld_flag_q;
    assign ld_cdb_val    = data_q;
    assign ld_cdb_rob_id = rob_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter against a byte-array memory model.
// Latency: n/a (testbench).
// Backpressure: drives io_buffer_full, rdy and flush directly.
module tb_ram_port_arbiter;

    localparam int ROBBW = 4;

    logic             clk = 1'b0;
    logic             rst, rdy, io_buffer_full;
    logic [7:0]       mem_din, mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;
    logic             if_req, flush, if_done;
    logic [31:0]      if_addr, if_data;
    logic             ls_req, ls_type, ls_done, ld_cdb_flag;
    logic [1:0]       ls_width;
    logic [31:0]      ls_addr, ls_val, ld_cdb_val;
    logic [ROBBW-1:0] ls_rob_id, ld_cdb_rob_id;

    // ram follows the DUT pins; shadow follows the bench's own idea of memory
    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        tb_last_ls;
    logic [31:0] last_if, last_ld;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ROBBW(ROBBW), .IO_MASK(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_type(ls_type), .ls_width(ls_width), .ls_addr(ls_addr),
        .ls_val(ls_val), .ls_rob_id(ls_rob_id), .ls_done(ls_done),
        .ld_cdb_flag(ld_cdb_flag), .ld_cdb_val(ld_cdb_val), .ld_cdb_rob_id(ld_cdb_rob_id)
    );

    // Synchronous byte RAM: read data appears one cycle after its address
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            r  = r | ({24'd0, shadow[ai[11:0]]} << (8 * i));
        end
        return r;
    endfunction

    task automatic run_ls(input logic typ, input logic [1:0] w, input logic [31:0] addr,
                          input logic [31:0] val, input logic [ROBBW-1:0] rob,
                          input int io_cyc, input int stall);
        int n, cyc, wr_cnt, lat;
        logic seen;
        logic [31:0] ai;
        n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        ls_type = typ; ls_width = w; ls_addr = addr; ls_val = val; ls_rob_id = rob;
        ls_req = 1'b1;
        io_buffer_full = (io_cyc > 0);
        cyc = 0; wr_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_wr) begin
                chk("wr_cycle", 32'(cyc), 32'(io_cyc + 1 + wr_cnt + ((wr_cnt > 0) ? stall : 0)));
                chk("wr_addr", mem_a, addr + 32'(wr_cnt));
                chk("wr_byte", {24'd0, mem_dout}, (val >> (8 * wr_cnt)) & 32'hFF);
                wr_cnt++;
            end
            if (ls_done) seen = 1'b1;
            if (io_cyc > 0 && cyc == io_cyc) io_buffer_full = 1'b0;
            if (stall > 0 && cyc == io_cyc + 1) begin
                rdy = 1'b0;
                #1 chk("rdy_low_no_wr", {31'd0, mem_wr}, 32'd0);
            end
            if (stall > 0 && cyc == io_cyc + 1 + stall) rdy = 1'b1;
        end
        chk("ls_done_seen", {31'd0, seen}, 32'd1);
        lat = (typ ? n + 1 : n + 2) + io_cyc + stall;
        chk("ls_latency", 32'(cyc), 32'(lat));
        chk("ld_flag", {31'd0, ld_cdb_flag}, {31'd0, !typ});
        if (typ) begin
            chk("wr_count", 32'(wr_cnt), 32'(n));
            for (int i = 0; i < n; i++) begin
                ai = addr + 32'(i);
                shadow[ai[11:0]] = val[8*i +: 8];
            end
        end else begin
            chk("wr_count", 32'(wr_cnt), 32'd0);
            chk("ld_val", ld_cdb_val, mem_word(addr, n));
            chk("ld_rob", {28'd0, ld_cdb_rob_id}, {28'd0, rob});
            last_ld = ld_cdb_val;
        end
        ls_req = 1'b0;
        io_buffer_full = 1'b0;
        rdy = 1'b1;
        tb_last_ls = 1'b1;
        @(negedge clk);
        chk("ls_done_pulse", {30'd0, ls_done, ld_cdb_flag}, 32'd0);
    endtask

    task automatic run_if(input logic [31:0] addr);
        int cyc;
        logic seen;
        if_addr = addr; if_req = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc <= 4) chk("if_addr", mem_a, addr + 32'(cyc - 1));
            if (mem_wr) chk("if_no_wr", {31'd0, mem_wr}, 32'd0);
            if (if_done) seen = 1'b1;
        end
        chk("if_done_seen", {31'd0, seen}, 32'd1);
        chk("if_latency", 32'(cyc), 32'd6);
        chk("if_data", if_data, mem_word(addr, 4));
        chk("if_no_ls_done", {31'd0, ls_done}, 32'd0);
        last_if = if_data;
        if_req = 1'b0;
        tb_last_ls = 1'b0;
        @(negedge clk);
        chk("if_done_pulse", {31'd0, if_done}, 32'd0);
    endtask

    // Both requesters stay pending; completion order must follow round-robin
    task automatic run_tie(input int nl, input int ni);
        int exp_q[$];
        int got_q[$];
        int rl, ri, cyc;
        logic last;
        rl = nl; ri = ni; last = tb_last_ls;
        while (rl > 0 || ri > 0) begin
            if (rl > 0 && (ri == 0 || !last)) begin
                exp_q.push_back(0); rl--; last = 1'b1;
            end else begin
                exp_q.push_back(1); ri--; last = 1'b0;
            end
        end
        rl = nl; ri = ni; cyc = 0;
        ls_type = 1'b0; ls_width = 2'd2; ls_addr = $urandom; ls_rob_id = 4'($urandom);
        if_addr = $urandom;
        ls_req = (rl > 0); if_req = (ri > 0);
        while ((rl > 0 || ri > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ls_done) begin
                got_q.push_back(0);
                chk("tie_ld_val", ld_cdb_val, mem_word(ls_addr, 4));
                rl--; tb_last_ls = 1'b1;
                if (rl > 0) ls_addr = $urandom; else ls_req = 1'b0;
            end
            if (if_done) begin
                got_q.push_back(1);
                chk("tie_if_data", if_data, mem_word(if_addr, 4));
                ri--; tb_last_ls = 1'b0;
                if (ri > 0) if_addr = $urandom; else if_req = 1'b0;
            end
        end
        ls_req = 1'b0; if_req = 1'b0;
        chk("tie_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("tie_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'd99, 32'(exp_q[i]));
        end
        @(negedge clk);
    endtask

    initial begin
        int cyc, if_seen, pulses, sel, io;
        logic typ;
        logic [31:0] a;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_type = 1'b0; ls_width = '0; ls_addr = '0; ls_val = '0; ls_rob_id = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            shadow[i] = ram[i];
        end
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        ram[12'h203] = 8'hAB;
        for (int i = 0; i < 4; i++) shadow[12'h100 + i] = ram[12'h100 + i];
        shadow[12'h203] = 8'hAB;

        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_pulses", {29'd0, if_done, ls_done, ld_cdb_flag}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ld_val", ld_cdb_val, 32'd0);
        chk("rst_rob", {28'd0, ld_cdb_rob_id}, 32'd0);
        rst = 1'b0;
        tb_last_ls = 1'b0;

        // Tie right after reset: LSB first, then alternate
        run_tie(2, 2);

        // Fetch with known instruction bytes
        run_if(32'h100);
        chk("fetch_word", last_if, 32'h00100513);

        // Byte load, zero-extended
        run_ls(1'b0, 2'd0, 32'h203, 32'h0, 4'd5, 0, 0);
        chk("ld_byte_ab", last_ld, 32'h000000AB);

        // Half store then read back
        run_ls(1'b1, 2'd1, 32'h400, 32'h0000BEEF, 4'd1, 0, 0);
        run_ls(1'b0, 2'd1, 32'h400, 32'h0, 4'd2, 0, 0);
        chk("half_readback", last_ld, 32'h0000BEEF);

        // IO store held off by a full buffer for 4 cycles
        run_ls(1'b1, 2'd0, 32'h30000, 32'h5A, 4'd3, 4, 0);

        // Word store with rdy dropped mid-flight, then read back
        run_ls(1'b1, 2'd2, 32'h500, 32'hCAFEF00D, 4'd4, 0, 3);
        run_ls(1'b0, 2'd3, 32'h500, 32'h0, 4'd6, 0, 0);
        chk("word_readback", last_ld, 32'hCAFEF00D);

        // Address wraps modulo 2^32
        run_ls(1'b1, 2'd1, 32'hFFFFFFFF, 32'h00001234, 4'd7, 0, 0);
        run_ls(1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 4'd8, 0, 0);
        chk("wrap_readback", last_ld, 32'h00001234);

        // Flush during fetch byte 2; a waiting load goes next
        if_addr = 32'h600; if_req = 1'b1; cyc = 0;
        while (mem_a !== 32'h602 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                ls_type = 1'b0; ls_width = 2'd2; ls_addr = 32'h604; ls_rob_id = 4'd9; ls_req = 1'b1;
            end
        end
        chk("flush_reach_byte2", mem_a, 32'h602);
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_mem_a", mem_a, 32'd0);
        chk("flush_no_if_done", {31'd0, if_done}, 32'd0);
        cyc = 0; if_seen = 0;
        while (!ls_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_done) if_seen++;
        end
        chk("flush_ls_latency", 32'(cyc), 32'd6);
        chk("flush_if_done_count", 32'(if_seen), 32'd0);
        chk("flush_ld_val", ld_cdb_val, mem_word(32'h604, 4));
        chk("flush_rob", {28'd0, ld_cdb_rob_id}, 32'd9);
        ls_req = 1'b0; tb_last_ls = 1'b1;
        @(negedge clk);

        // Reset in the middle of a word load
        ls_type = 1'b0; ls_width = 2'd2; ls_addr = 32'h700; ls_rob_id = 4'd11; ls_req = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_a", mem_a, 32'd0);
        chk("midrst_pulses", {29'd0, if_done, ls_done, ld_cdb_flag}, 32'd0);
        chk("midrst_ld_val", ld_cdb_val, 32'd0);
        chk("midrst_rob", {28'd0, ld_cdb_rob_id}, 32'd0);
        rst = 1'b0; tb_last_ls = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (ls_done || ld_cdb_flag || if_done) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);

        // Randomized single transactions
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                run_if($urandom);
            end else begin
                typ = 1'($urandom);
                a = $urandom;
                io = 0;
                if (typ && $urandom_range(0, 3) == 0) begin
                    io = $urandom_range(1, 3);
                    a[17:16] = 2'b11;
                end
                run_ls(typ, 2'($urandom), a, $urandom, 4'($urandom), io, 0);
            end
        end
        run_tie(2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Sequencer and arbiter for the single byte-wide RAM port shared by instruction fetch (IF) and the load/store buffer (LSB). It accepts one word-or-narrower transaction at a time from either requester and splits it into per-byte RAM cycles. It assembles load data, returns one-cycle completion pulses and broadcasts load results on the load CDB. It sits between IF/LSB and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins, and adds fair arbitration, IO back-pressure and IF flush.

## Interface
- `ROBBW`, default `ROBBW` from `Def.v`: ROB index width.
- `IO_MASK`, default 2'b11: value of `addr[17:16]` that marks an IO address.
- `clk` in 1: single clock, posedge.
- `rst` in 1: **synchronous, active-high** reset.
- `rdy` in 1: global enable; low freezes all state.
- `io_buffer_full` in 1: IO output buffer full.
- `mem_din` in 8: RAM read byte, valid one cycle after its address.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `if_req` in 1: fetch request; held with `if_addr` until `if_done` or `flush`.
- `if_addr` in 32: fetch address (4 bytes).
- `flush` in 1: misprediction rollback; aborts IF work only.
- `if_done` out 1: one-cycle pulse that qualifies `if_data`.
- `if_data` out 32: fetched word, little-endian.
- `ls_req` in 1: LSB request; held with its operands until `ls_done`.
- `ls_type` in 1: 0 = load, 1 = store.
- `ls_width` in 2: 0 = byte, 1 = half, 2 = word, 3 = word.
- `ls_addr` in 32: LSB byte address.
- `ls_val` in 32: store data.
- `ls_rob_id` in ROBBW: ROB entry of the request.
- `ls_done` out 1: one-cycle pulse, load or store complete.
- `ld_cdb_flag` out 1: one-cycle pulse, coincident with `ls_done` on loads.
- `ld_cdb_val` out 32: load data, zero-extended to 32 bits.
- `ld_cdb_rob_id` out ROBBW: latched `ls_rob_id`.

## Operation
- **States.** IDLE, RUN, IO_WAIT, DONE.
- **IDLE.**
  - Requests are sampled each edge. `flush` masks `if_req` that cycle.
  - If only one request is present, that requester is granted.
  - If both are present, the requester not granted last wins (round-robin).
  - On grant: latch base address, N (1/2/4), type, value and rob_id; clear `cnt`; set `last_grant`.
  - The next state is RUN. For a store whose address matches `IO_MASK` while `io_buffer_full` is high, the next state is IO_WAIT instead.
- **IO_WAIT.**
  - `mem_wr` = 0.
  - Go to RUN on the first edge that sees `io_buffer_full` low.
- **RUN.**
  - `mem_a` = base + `cnt` (32-bit add; wraps modulo 2^32).
  - Store:
    - `mem_wr` = 1 while `cnt` < N.
    - `mem_dout` = byte `cnt` of the value.
    - When the edge sees `cnt` == N-1, go to DONE and set `ls_done`.
  - Load or fetch:
    - `mem_wr` = 0.
    - Each edge with `cnt` ≥ 1 captures `mem_din` into byte `cnt`-1.
    - When the edge sees `cnt` == N (the capture of the last byte), go to DONE and set the done pulse(s).
  - `cnt` increments on each RUN edge.
- **DONE.**
  - Lasts one cycle. The done outputs are high for this cycle only.
  - Requests are ignored in this cycle. Next state is IDLE.
- **Flush.** If `flush` is high while an IF transaction is in RUN, the next state is IDLE with no `if_done`. A flush that arrives in the IF DONE cycle does not retract the pulse. LSB transactions ignore `flush`.
- **Load data.** Unfetched upper bytes of `ld_cdb_val` are 0. Sign extension happens downstream.
- **Reset.**
  - State = IDLE, `cnt` = 0, `last_grant` = IF, so LSB wins the first tie.
  - All outputs are 0, including `mem_a`, `mem_dout`, `if_data`, `ld_cdb_val` and `ld_cdb_rob_id`.
  - Reset mid-transaction discards it. No done pulse is produced.
- **`rdy` low.** State, `cnt` and latches hold. `mem_wr` is forced to 0. Pulses stay at their registered value.

## Timing
- E0 is the grant edge in IDLE.
- Store of N bytes: write bytes are on the pins in the N cycles after E0. `ls_done` is high in the cycle after edge E0+N. Total occupancy is N+1 cycles. IO_WAIT cycles are added to this.
- Load/fetch of N bytes: read addresses are on the pins in the N cycles after E0. The done pulse is high in the cycle after edge E0+N+1. A 4-byte fetch takes 6 cycles from grant to the next possible grant.
- The next grant can occur at the DONE→IDLE edge + 1, i.e. the request is sampled in the IDLE cycle.
- `mem_wr`, `mem_a` and `mem_dout` decode combinationally from registered state. No input reaches the RAM pins combinationally.

## Structure
- Shared package:
  - state encoding (IDLE/RUN/IO_WAIT/DONE);
  - width codes (0/1/2);
  - the ls_type values;
  - the `IO_MASK` field position [17:16].
- `ROBBW` stays in `Def.v`.
- One sub-module, `rr_arb2`: a two-requester round-robin picker with a `last_grant` register, exercised only in IDLE.

## Test plan
- **Fetch.** `if_req`, addr 0x100, RAM bytes 0x13,0x05,0x10,0x00 → `mem_a` 0x100..0x103, `if_done` 1 cycle, `if_data` 0x00100513.
- **Signed byte load, zero-extended.** Byte load at 0x203 = 0xAB, rob_id 5 → `ld_cdb_flag` + `ls_done` together, `ld_cdb_val` 0x000000AB, `ld_cdb_rob_id` 5.
- **Tie arbitration after reset.** `if_req` and `ls_req` asserted together after reset → LSB granted first, IF second. Repeat with both pending → grants alternate.
- **Half store.** Store half 0xBEEF to 0x400 → `mem_wr` high 2 cycles, bytes 0xEF@0x400, 0xBE@0x401, `ls_done` after 3 cycles.
- **IO back-pressure.** Byte store to 0x30000 with `io_buffer_full` high 4 cycles → `mem_wr` stays 0 until full drops, then one write, then `ls_done`.
- **Flush and reset mid-transaction.**
  - `flush` during fetch byte 2 → no `if_done`; a pending `ls_req` is granted at the next IDLE.
  - `rst` during a load → all outputs 0, no done pulse.
